// File: rtl/flag_branch_unit.sv
// Flag register and B/CALL/RET resolver with registered PC redirect.
// Define FLAG_FWD_EN to forward ALU flags into branch conditions (no stall).
module flag_branch_unit #(
  parameter int PC_W   = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [3:0]        alu_op,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [DATA_W-1:0] br_instr,
  input  logic [PC_W-1:0]   br_pc,
  input  logic [PC_W-1:0]   br_reg,
  output logic [2:0]        flags,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              br_taken
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    FLUSH
  } state_t;

  state_t state, state_nxt;

  logic [3:0]      op;
  logic [2:0]      cond;
  logic            is_b, is_call, is_ret;
  logic            op_arith, op_logic;
  logic [2:0]      flags_nxt, f_eff;
  logic            fz, fn, fv;
  logic            cond_ok, taken;
  logic            hazard, accept, fire;
  logic [PC_W-1:0] target;

  assign op       = br_instr[15:12];
  assign cond     = br_instr[11:9];
  assign is_b     = op == 4'hC;
  assign is_call  = op == 4'hD;
  assign is_ret   = op == 4'hE;
  assign op_arith = alu_op[3:1] == 3'b000;
  assign op_logic = ~alu_op[3] & ~op_arith;

  always_comb begin
    flags_nxt = flags;
    if (alu_valid) begin
      unique case (1'b1)
        op_arith: flags_nxt = {alu_z, alu_n, alu_v};
        op_logic: flags_nxt[2] = alu_z;
        default: ;
      endcase
    end
  end

`ifdef FLAG_FWD_EN
  assign f_eff  = flags_nxt;
  assign hazard = 1'b0;
`else
  assign f_eff  = flags;
  assign hazard = br_valid & alu_valid & is_b & (cond != 3'b111);
`endif

  assign {fz, fn, fv} = f_eff;

  always_comb begin
    cond_ok = 1'b0;
    unique case (cond)
      3'b000: cond_ok = ~fz;
      3'b001: cond_ok = fz;
      3'b010: cond_ok = ~fz & ~fn;
      3'b011: cond_ok = fn;
      3'b100: cond_ok = fz | ~fn;
      3'b101: cond_ok = fn | fz;
      3'b110: cond_ok = fv;
      3'b111: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign taken = (is_b & cond_ok) | is_call | is_ret;

  always_comb begin
    target = br_reg;
    unique case (1'b1)
      is_b:
        target = br_pc + PC_W'(1)
               + {{(PC_W-9){br_instr[8]}}, br_instr[8:0]};
      is_call:
        target = br_pc + PC_W'(1)
               + {{(PC_W-12){br_instr[11]}}, br_instr[11:0]};
      default: target = br_reg;
    endcase
  end

  assign accept = br_valid & br_ready;
  assign fire   = accept & taken;

  always_comb begin
    state_nxt = state;
    br_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        br_ready = ~hazard;
        if (hazard)    state_nxt = HOLD;
        else if (fire) state_nxt = FLUSH;
      end
      HOLD: begin
        br_ready  = 1'b1;
        state_nxt = fire ? FLUSH : IDLE;
      end
      FLUSH: begin
        br_ready  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) br_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      flags       <= 3'b000;
      redirect    <= 1'b0;
      br_taken    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state    <= state_nxt;
      flags    <= flags_nxt;
      redirect <= fire;
      br_taken <= fire;
      if (fire) redirect_pc <= target;
    end
  end

endmodule
